pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic pipeline register for the processor datapath. It generalises the fixed inter-stage latches to any datapath and control width and to a chain of DEPTH slots. Each slot has a valid bit, valid/ready backpressure with bubble collapse, and a flush that turns every in-flight entry into a NOP bubble. It sits between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB), and a multi-cycle unit can use it as a short delay line.

## Interface
- DATA_W, 160: width of the datapath bundle (pc, operands, immediate, instruction, ...); never cleared by flush.
- CTRL_W, 10: width of the control bundle (alu_op, write enables, select fields); forced to 0 in every invalid slot.
- DEPTH, 1: number of register slots in the chain; legal range 1..8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a beat.
- in_ready  out  1  slot 0 accepts this cycle.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  last slot holds a valid beat.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  last-slot datapath bundle.
- out_ctrl  out  CTRL_W  last-slot control bundle; 0 whenever out_valid=0.
- flush  in  1  kill all in-flight beats (branch/jump redirect).
- occupancy  out  clog2(DEPTH+1)  number of valid slots.

## Operation
- Slot i holds three fields: v[i], d[i] and c[i]. Slot DEPTH-1 drives the outputs.
- Advance rule:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - in_ready = adv[0].
  - A bubble in any slot lets the entries upstream of it move forward even while out_ready=0 (bubble collapse).
- When adv[i]=1, slot i loads from its predecessor; slot 0's predecessor is the input port.
  - v[i] and d[i] copy the predecessor.
  - c[i] copies the predecessor's control when the predecessor is valid, and is set to 0 when it is not.
- When adv[i]=0, slot i holds all three fields.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Flush, on the next edge:
  - all v to 0 and all c to 0.
  - Data registers follow the normal advance rule and are not cleared.
  - A beat presented at the input in the flush cycle is dropped, even though in_ready may read 1.
  - out_fire in the flush cycle still counts as consumed downstream.
- Occupancy:
  - A registered counter: +in_fire, -out_fire.
  - Set to 0 on flush.
  - Must equal the popcount of v at every edge.
- Reset: all v, d and c are 0 and occupancy is 0. Consequences: out_valid=0, out_data=0, out_ctrl=0, and in_ready=1. Reset overrides flush and every handshake.
- Asserting rst while slots are full discards their contents with no output beat.

## Timing
- Latency: with out_ready held at 1, a beat accepted at edge k appears on out_* right after edge k+DEPTH-1. For DEPTH=1 that is the cycle after capture.
- Throughput: 1 beat/cycle when out_ready stays 1.
- Full chain with out_ready=0: in_ready=0 in the same cycle. in_ready returns to 1 in the same cycle that out_ready rises.
- Ready path: in_ready is combinational from out_ready through the adv chain, DEPTH AND/OR levels. There is no combinational path from in_valid to any output.
- Simultaneous in_fire and out_fire with a full chain: every slot shifts and occupancy is unchanged.

## Structure
- Shared header pipe_defs.vh holds:
  - PIPE_CTRL_NOP (all-zero control value).
  - The clog2 helper function used for occupancy width.
  - Named field offsets into the ctrl bundle for the ID/EXE instance (alu_op[5:0], data_wr, wr_en, sel_data[1:0]).
- Sub-module pipe_slot: one slot holding v, d and c, plus the adv/load logic. It is instantiated DEPTH times in a generate loop.
- The top level contains only the chaining, flush fan-out and the occupancy counter.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, then release. Expected:
  - While rst=1: out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
  - After release: in_ready=1.
- Streaming, DEPTH=3, out_ready=1: push data 1..5 with ctrl 0x3F on consecutive cycles. Expected:
  - out_data 1..5 emerges in order, with the first beat 2 cycles after its capture edge.
  - Occupancy stays at 3 in steady state.
- Backpressure and collapse, DEPTH=3:
  - Push A, send a bubble, then push B, with out_ready=0. Expected: A reaches the last slot, then B collapses into slot 1. in_ready stays 1 until the cycle B is held behind A with slot 0 also filled by C (chain full, occupancy=3); from then on in_ready=0.
  - Raise out_ready. Expected: A, B and C are delivered on consecutive cycles.
- Flush mid-stream, DEPTH=2: chain full (occupancy=2), assert flush together with in_valid=1 carrying ctrl 0x2A. Expected on the next cycle:
  - out_valid=0, out_ctrl=0, occupancy=0.
  - The 0x2A beat never appears at the output.
- Simultaneous fire with a full chain: out_ready=1 and in_valid=1 every cycle for 10 cycles. Expected: occupancy stays at DEPTH, and no beat is lost or duplicated (scoreboard).
- Reset mid-operation: with 2 valid slots, pulse rst for 1 cycle. Expected:
  - Next cycle: out_valid=0, occupancy=0.
  - A subsequent push emerges after exactly DEPTH cycles.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline register: width helper and the
// ID/EXE control bundle layout carried in the ctrl field.
package pipe_stage_reg_pkg;

  // Bits needed to count 0..value-1; used to size the occupancy counter.
  function automatic int pipe_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // ID/EXE control bundle, MSB first: alu_op[9:4], data_wr[3], wr_en[2], sel_data[1:0].
  typedef struct packed {
    logic [5:0] alu_op;
    logic       data_wr;
    logic       wr_en;
    logic [1:0] sel_data;
  } id_exe_ctrl_t;

  localparam int ID_EXE_CTRL_W    = $bits(id_exe_ctrl_t);
  localparam int SEL_DATA_LSB     = 0;
  localparam int WR_EN_BIT        = 2;
  localparam int DATA_WR_BIT      = 3;
  localparam int ALU_OP_LSB       = 4;

  localparam id_exe_ctrl_t PIPE_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between an upstream stage, the pipeline register and the
// downstream stage; master drives the stage inputs, slave is the register.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10,
  parameter int DEPTH  = 1
);
  localparam int OCC_W = pipe_clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One slot of the elastic chain: valid bit, datapath and control registers,
// loading from the predecessor whenever the slot is allowed to advance.
module pipe_stage_reg_slot #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_adv,
  input  logic              i_prev_v,
  input  logic [DATA_W-1:0] i_prev_d,
  input  logic [CTRL_W-1:0] i_prev_c,
  output logic              o_v,
  output logic [DATA_W-1:0] o_d,
  output logic [CTRL_W-1:0] o_c
);

  logic              r_v;
  logic [DATA_W-1:0] r_d;
  logic [CTRL_W-1:0] r_c;
  logic              w_load_v;

  // A flushed beat enters as a bubble, so its control is forced to NOP.
  assign w_load_v = i_prev_v & ~i_flush;

  // NOTE: sequential state uses non-blocking assignments only, so every slot
  // samples its predecessor's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath register is reset too, because out_data must read 0
      // straight after reset; it is a handful of flops, not a RAM.
      r_v <= 1'b0;
      r_d <= '0;
      r_c <= '0;
    end else if (i_adv) begin
      r_v <= w_load_v;
      r_d <= i_prev_d;
      r_c <= w_load_v ? i_prev_c : '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
      r_c <= '0;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;
  assign o_c = r_c;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register of DEPTH slots with valid/ready backpressure,
// bubble collapse, flush-to-NOP and an occupancy counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 10,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   bus
);

  localparam int OCC_W = pipe_clog2(DEPTH + 1);

  logic [DEPTH-1:0]  w_v;
  logic [DEPTH-1:0]  w_adv;
  logic [DEPTH-1:0]  w_prev_v;
  logic [DATA_W-1:0] w_d      [DEPTH];
  logic [CTRL_W-1:0] w_c      [DEPTH];
  logic [DATA_W-1:0] w_prev_d [DEPTH];
  logic [CTRL_W-1:0] w_prev_c [DEPTH];
  logic              w_run;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [OCC_W-1:0]  r_occ;

  // A slot may advance if it is empty or everything downstream advances;
  // the running OR lets beats collapse into any bubble ahead of them.
  always_comb begin
    // NOTE: every variable assigned here gets a value before any branch or
    // loop so that no path leaves it holding state (no inferred latch).
    w_run = bus.out_ready;
    w_adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_run    = ~w_v[i] | w_run;
      w_adv[i] = w_run;
    end
  end

  always_comb begin
    w_prev_v    = '0;
    w_prev_v[0] = bus.in_valid;
    w_prev_d[0] = bus.in_data;
    w_prev_c[0] = bus.in_ctrl;
    for (int i = 1; i < DEPTH; i++) begin
      w_prev_v[i] = w_v[i-1];
      w_prev_d[i] = w_d[i-1];
      w_prev_c[i] = w_c[i-1];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    pipe_stage_reg_slot #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_flush  (bus.flush),
      .i_adv    (w_adv[gi]),
      .i_prev_v (w_prev_v[gi]),
      .i_prev_d (w_prev_d[gi]),
      .i_prev_c (w_prev_c[gi]),
      .o_v      (w_v[gi]),
      .o_d      (w_d[gi]),
      .o_c      (w_c[gi])
    );
  end

  assign w_in_fire  = bus.in_valid & w_adv[0];
  assign w_out_fire = w_v[DEPTH-1] & bus.out_ready;

  // A flush empties every slot, so the count restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= '0;
    end else if (bus.flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_in_fire) - OCC_W'(w_out_fire);
    end
  end

  assign bus.in_ready  = w_adv[0];
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1];
  assign bus.out_ctrl  = w_c[DEPTH-1];
  assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios followed by random
// traffic, checked against an ordered-queue model of in-flight beats.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int DEPTH  = 3;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    int                cap;
  } beat_t;

  logic clk;
  logic rst;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) bus ();

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];
  beat_t b;
  int    edge_n   = 0;
  bit    model_ok = 0;
  bit    after_rst = 0;
  bit    exp_ov;
  bit    exp_ir;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks outputs mid-cycle, then updates the model for the coming edge.
  // The oldest beat reaches the last slot DEPTH-1 edges after capture, since
  // nothing ahead of it can block it; the chain refuses input only when full
  // and the downstream stage is stalled.
  always @(negedge clk) begin
    exp_ov = (q.size() != 0) && (edge_n >= q[0].cap + DEPTH - 1);
    exp_ir = (q.size() < DEPTH) || bus.out_ready;
    if (model_ok) begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
      check("occupancy", 64'(bus.occupancy), 64'(q.size()));
      if (exp_ov) begin
        check("out_data", 64'(bus.out_data), 64'(q[0].d));
        check("out_ctrl", 64'(bus.out_ctrl), 64'(q[0].c));
      end else begin
        check("out_ctrl_nop", 64'(bus.out_ctrl), 64'd0);
      end
      if (after_rst) check("out_data_reset", 64'(bus.out_data), 64'd0);
    end
    if (rst) begin
      q.delete();
      model_ok  = 1;
      after_rst = 1;
    end else if (model_ok) begin
      after_rst = 0;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (exp_ov && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && exp_ir) begin
          b.d   = bus.in_data;
          b.c   = bus.in_ctrl;
          b.cap = edge_n + 1;
          q.push_back(b);
        end
      end
    end
    edge_n++;
  end

  initial begin
    // Reset held two cycles with a beat offered at the input.
    drive(1, 32'hDEAD_BEEF, 10'h155, 1, 0, 1);
    drive(1, 32'hDEAD_BEEF, 10'h155, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 0);

    // Streaming 1..5 with ctrl 0x3F.
    for (int i = 1; i <= 5; i++) drive(1, DATA_W'(i), 10'h03F, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0);

    // Backpressure with a bubble, then release.
    drive(1, 32'hA, 10'h011, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 32'hB, 10'h022, 0, 0, 0);
    drive(1, 32'hC, 10'h033, 0, 0, 0);
    repeat (3) drive(1, 32'hD, 10'h044, 0, 0, 0);
    drive(1, 32'hD, 10'h044, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0);

    // Fill, then flush with a 0x2A beat offered in the same cycle.
    for (int i = 0; i < DEPTH; i++) drive(1, 32'h100 + DATA_W'(i), 10'h07F, 0, 0, 0);
    drive(1, 32'h2A2A, 10'h02A, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 1, 0, 0);

    // Full chain with simultaneous in/out fire for 10 cycles.
    for (int i = 0; i < DEPTH; i++) drive(1, 32'h200 + DATA_W'(i), 10'h101, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 32'h300 + DATA_W'(i), 10'h202, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0);

    // Reset pulse with two valid slots, then one push.
    drive(1, 32'h400, 10'h0AA, 0, 0, 0);
    drive(1, 32'h401, 10'h0BB, 0, 0, 0);
    drive(1, 32'h402, 10'h0CC, 0, 0, 1);
    drive(1, 32'h403, 10'h0DD, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      drive(logic'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 63) == 0));
    end
    repeat (DEPTH + 3) drive(0, 0, 0, 1, 0, 0);

    check("drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
